// File: rtl/stream_addr_demux_ordered.sv
// Address-decoding stream demux with one registered output stage.
// A new target is only selected once every beat sent to the previous target has been retired.
module stream_addr_demux_ordered #(
    parameter int unsigned NrOutput     = 2,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned NrRules      = 4,
    parameter int unsigned DefaultSlave = 0,
    parameter int unsigned MaxTrans     = 8,
    localparam int unsigned SelW        = (NrOutput > 2) ? $clog2(NrOutput) : 1,
    localparam int unsigned CntW        = $clog2(MaxTrans + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            inp_valid_i,
    output logic                            inp_ready_o,
    input  logic [AddressWidth-1:0]         inp_addr_i,
    output logic [NrOutput-1:0]             oup_valid_o,
    input  logic [NrOutput-1:0]             oup_ready_i,
    output logic [SelW-1:0]                 oup_sel_o,
    output logic                            oup_dec_err_o,
    input  logic                            rsp_done_i,
    input  logic [NrRules-1:0]              rule_en_i,
    input  logic [NrRules*AddressWidth-1:0] addr_base_i,
    input  logic [NrRules*AddressWidth-1:0] addr_mask_i,
    input  logic [NrRules*SelW-1:0]         addr_slave_i,
    output logic [CntW-1:0]                 outstanding_o,
    output logic                            busy_o
);

    if (NrOutput < 2) begin : g_chk_nr_output
        $error("NrOutput must be at least 2");
    end
    if (DefaultSlave >= NrOutput) begin : g_chk_default_slave
        $error("DefaultSlave must be below NrOutput");
    end
    if (MaxTrans < 1) begin : g_chk_max_trans
        $error("MaxTrans must be at least 1");
    end

    logic            valid_q;
    logic [SelW-1:0] sel_q;
    logic            err_q;
    logic [SelW-1:0] last_q;
    logic [CntW-1:0] cnt_q;

    logic [SelW-1:0] tgt;
    logic            err;
    logic            found;
    logic            drain;
    logic            accept;
    logic            retire;

    // Lowest-index enabled match wins; the found flag stops later rules from overriding it.
    always_comb begin
        tgt   = SelW'(DefaultSlave);
        err   = 1'b1;
        found = 1'b0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (!found && rule_en_i[i] &&
                (((inp_addr_i ^ addr_base_i[i*AddressWidth +: AddressWidth])
                  & addr_mask_i[i*AddressWidth +: AddressWidth]) == '0)) begin
                found = 1'b1;
                tgt   = addr_slave_i[i*SelW +: SelW];
                err   = 1'b0;
            end
        end
    end

    assign drain  = valid_q & oup_ready_i[sel_q];
    assign retire = rsp_done_i & (cnt_q != '0);

    // rsp_done_i deliberately stays out of the ready path: a retire only opens ready next cycle.
    assign inp_ready_o = (!valid_q || drain)
                       && ((cnt_q == '0) || (tgt == last_q))
                       && (cnt_q < CntW'(MaxTrans));
    assign accept = inp_valid_i & inp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                sel_q   <= tgt;
                err_q   <= err;
                last_q  <= tgt;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (accept && !retire) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!accept && retire) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    always_comb begin
        oup_valid_o = '0;
        for (int unsigned k = 0; k < NrOutput; k++) begin
            oup_valid_o[k] = valid_q && (sel_q == SelW'(k));
        end
    end

    assign oup_sel_o     = sel_q;
    assign oup_dec_err_o = err_q;
    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0);

    property p_no_spurious_retire;
        @(posedge clk_i) disable iff (rst_i) !(rsp_done_i && (cnt_q == '0));
    endproperty
    a_no_spurious_retire: assert property (p_no_spurious_retire);

endmodule

// File: tb/tb_stream_addr_demux_ordered.sv
// Scoreboard bench for stream_addr_demux_ordered: a 4-output instance for routing/ordering and
// a MaxTrans=2 instance for the outstanding limit.
module tb_stream_addr_demux_ordered;

    localparam int AW = 16;

    typedef struct packed {
        logic [1:0] sel;
        logic       err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          inp_valid;
    logic          inp_valid2;
    logic [AW-1:0] addr;
    logic [3:0]    oup_ready;
    logic          rsp_done;
    logic          rsp_done2;
    logic [3:0]    rule_en;
    logic [4*AW-1:0] rule_base;
    logic [4*AW-1:0] rule_mask;
    logic [7:0]    rule_slave;

    logic          inp_ready_o;
    logic [3:0]    oup_valid_o;
    logic [1:0]    oup_sel_o;
    logic          oup_dec_err_o;
    logic [3:0]    outstanding_o;
    logic          busy_o;

    logic          ready2;
    logic [3:0]    oup_valid2;
    logic [1:0]    sel2;
    logic          err2;
    logic [1:0]    outstanding2;
    logic          busy2;

    int checks;
    int failures;
    exp_t sb[$];

    stream_addr_demux_ordered #(
        .NrOutput(4), .AddressWidth(AW), .NrRules(4), .DefaultSlave(0), .MaxTrans(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .inp_valid_i(inp_valid), .inp_ready_o(inp_ready_o), .inp_addr_i(addr),
        .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready), .oup_sel_o(oup_sel_o),
        .oup_dec_err_o(oup_dec_err_o), .rsp_done_i(rsp_done),
        .rule_en_i(rule_en), .addr_base_i(rule_base), .addr_mask_i(rule_mask),
        .addr_slave_i(rule_slave), .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    stream_addr_demux_ordered #(
        .NrOutput(4), .AddressWidth(AW), .NrRules(4), .DefaultSlave(0), .MaxTrans(2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .inp_valid_i(inp_valid2), .inp_ready_o(ready2), .inp_addr_i(addr),
        .oup_valid_o(oup_valid2), .oup_ready_i(oup_ready), .oup_sel_o(sel2),
        .oup_dec_err_o(err2), .rsp_done_i(rsp_done2),
        .rule_en_i(rule_en), .addr_base_i(rule_base), .addr_mask_i(rule_mask),
        .addr_slave_i(rule_slave), .outstanding_o(outstanding2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rules();
        rule_en    = '0;
        rule_base  = '0;
        rule_mask  = '0;
        rule_slave = '0;
    endtask

    task automatic set_rule(input int i, input logic [AW-1:0] b, input logic [AW-1:0] m,
                            input logic [1:0] s, input logic en);
        rule_base[i*AW +: AW] = b;
        rule_mask[i*AW +: AW] = m;
        rule_slave[i*2 +: 2]  = s;
        rule_en[i]            = en;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (oup_valid_o !== 4'b0000) begin failures++; $display("FAIL reset_valid: got %b want 0000", oup_valid_o); end
        checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", outstanding_o); end
        checks++; if ({busy_o, oup_dec_err_o, oup_sel_o} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {busy_o, oup_dec_err_o, oup_sel_o}); end
        checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", inp_ready_o); end
        checks++; if ({ready2, outstanding2} !== 3'b100) begin failures++; $display("FAIL reset_dut2: got %b want 100", {ready2, outstanding2}); end
    endtask

    task automatic test_basic();
        exp_t e;
        logic [6:0] got, want;
        logic [AW-1:0] addrs [2];
        logic [1:0] tgts [2];
        addrs[0] = 16'h1234; tgts[0] = 2'd1;
        addrs[1] = 16'h2ABC; tgts[1] = 2'd2;
        clear_rules();
        set_rule(0, 16'h1000, 16'hF000, 2'd1, 1'b1);
        set_rule(1, 16'h2000, 16'hF000, 2'd2, 1'b1);
        oup_ready = 4'hF;
        for (int n = 0; n < 2; n++) begin
            addr = addrs[n];
            inp_valid = 1'b1;
            #1;
            checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready%0d: got %b want 1", n, inp_ready_o); end
            sb.push_back('{sel: tgts[n], err: 1'b0});
            tick();
            inp_valid = 1'b0;
            checks++; if (outstanding_o !== 4'd1) begin failures++; $display("FAIL basic_cnt%0d: got %0d want 1", n, outstanding_o); end
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL basic_sb%0d: output with empty scoreboard", n); end
            else begin
                e = sb.pop_front();
                got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
                want = {4'b0001 << e.sel, e.sel, e.err};
                if (got !== want) begin failures++; $display("FAIL basic_out%0d: got %b want %b", n, got, want); end
            end
            rsp_done = 1'b1;
            tick();
            rsp_done = 1'b0;
            checks++; if ({oup_valid_o, outstanding_o} !== 8'h00) begin failures++; $display("FAIL basic_retire%0d: got %h want 00", n, {oup_valid_o, outstanding_o}); end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [6:0] got, want;
        logic [AW-1:0] addrs [3];
        logic [1:0] tgts [3];
        addrs[0] = 16'h1000; tgts[0] = 2'd3;
        addrs[1] = 16'h1000; tgts[1] = 2'd1;
        addrs[2] = 16'h5008; tgts[2] = 2'd0;
        clear_rules();
        set_rule(0, 16'h0000, 16'h0000, 2'd3, 1'b1);
        set_rule(1, 16'h1000, 16'hF000, 2'd1, 1'b1);
        set_rule(2, 16'h5000, 16'hF000, 2'd0, 1'b1);
        oup_ready = 4'hF;
        for (int n = 0; n < 3; n++) begin
            if (n == 1) rule_en[0] = 1'b0;
            addr = addrs[n];
            inp_valid = 1'b1;
            #1;
            checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL prio_ready%0d: got %b want 1", n, inp_ready_o); end
            sb.push_back('{sel: tgts[n], err: 1'b0});
            tick();
            inp_valid = 1'b0;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL prio_sb%0d: output with empty scoreboard", n); end
            else begin
                e = sb.pop_front();
                got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
                want = {4'b0001 << e.sel, e.sel, e.err};
                if (got !== want) begin failures++; $display("FAIL prio_out%0d: got %b want %b", n, got, want); end
            end
            rsp_done = 1'b1;
            tick();
            rsp_done = 1'b0;
        end
        checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL prio_cnt: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_target_switch();
        exp_t e;
        logic [6:0] got, want;
        clear_rules();
        set_rule(0, 16'h1000, 16'hF000, 2'd1, 1'b1);
        set_rule(1, 16'h2000, 16'hF000, 2'd2, 1'b1);
        oup_ready = 4'hF;
        addr = 16'h1000;
        inp_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL switch_ready%0d: got %b want 1", b, inp_ready_o); end
            sb.push_back('{sel: 2'd1, err: 1'b0});
            tick();
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL switch_sb%0d: output with empty scoreboard", b); end
            else begin
                e = sb.pop_front();
                got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
                want = {4'b0001 << e.sel, e.sel, e.err};
                if (got !== want) begin failures++; $display("FAIL switch_out%0d: got %b want %b", b, got, want); end
            end
        end
        addr = 16'h2000;
        #1;
        checks++; if ({inp_ready_o, outstanding_o} !== 5'b0_0011) begin failures++; $display("FAIL switch_stall: got %b want 00011", {inp_ready_o, outstanding_o}); end
        for (int p = 0; p < 3; p++) begin
            rsp_done = 1'b1;
            #1;
            checks++; if (inp_ready_o !== 1'b0) begin failures++; $display("FAIL switch_wait%0d: got %b want 0", p, inp_ready_o); end
            tick();
            rsp_done = 1'b0;
        end
        #1;
        checks++; if ({inp_ready_o, oup_valid_o, outstanding_o} !== 9'b1_0000_0000) begin failures++; $display("FAIL switch_open: got %b want 100000000", {inp_ready_o, oup_valid_o, outstanding_o}); end
        sb.push_back('{sel: 2'd2, err: 1'b0});
        tick();
        inp_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL switch_sb_new: output with empty scoreboard"); end
        else begin
            e = sb.pop_front();
            got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
            want = {4'b0001 << e.sel, e.sel, e.err};
            if (got !== want) begin failures++; $display("FAIL switch_out_new: got %b want %b", got, want); end
        end
        checks++; if (outstanding_o !== 4'd1) begin failures++; $display("FAIL switch_cnt_new: got %0d want 1", outstanding_o); end
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
    endtask

    task automatic test_max_trans();
        clear_rules();
        set_rule(0, 16'h1000, 16'hF000, 2'd1, 1'b1);
        oup_ready = 4'hF;
        addr = 16'h1000;
        inp_valid2 = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++; if (ready2 !== 1'b1) begin failures++; $display("FAIL max_ready%0d: got %b want 1", b, ready2); end
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if ({ready2, outstanding2, busy2} !== 4'b0101) begin failures++; $display("FAIL max_stall%0d: got %b want 0101", s, {ready2, outstanding2, busy2}); end
            tick();
        end
        rsp_done2 = 1'b1;
        #1;
        checks++; if (ready2 !== 1'b0) begin failures++; $display("FAIL max_no_comb: got %b want 0", ready2); end
        tick();
        rsp_done2 = 1'b0;
        #1;
        checks++; if ({ready2, outstanding2} !== 3'b101) begin failures++; $display("FAIL max_reopen: got %b want 101", {ready2, outstanding2}); end
        rsp_done2 = 1'b1;
        tick();
        rsp_done2 = 1'b0;
        inp_valid2 = 1'b0;
        checks++; if ({oup_valid2, outstanding2} !== 6'b0010_01) begin failures++; $display("FAIL max_acc_ret: got %b want 001001", {oup_valid2, outstanding2}); end
        rsp_done2 = 1'b1;
        tick();
        rsp_done2 = 1'b0;
        checks++; if (outstanding2 !== 2'd0) begin failures++; $display("FAIL max_drain: got %0d want 0", outstanding2); end
    endtask

    task automatic test_dec_err_hold();
        exp_t e;
        logic [6:0] got, want;
        clear_rules();
        set_rule(0, 16'h1000, 16'hF000, 2'd1, 1'b1);
        set_rule(1, 16'h2000, 16'hF000, 2'd2, 1'b1);
        oup_ready = 4'h0;
        addr = 16'h7000;
        inp_valid = 1'b1;
        #1;
        checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL err_ready: got %b want 1", inp_ready_o); end
        sb.push_back('{sel: 2'd0, err: 1'b1});
        tick();
        inp_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL err_sb: output with empty scoreboard"); end
        else begin
            e = sb.pop_front();
            got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
            want = {4'b0001 << e.sel, e.sel, e.err};
            if (got !== want) begin failures++; $display("FAIL err_out: got %b want %b", got, want); end
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({oup_valid_o, oup_sel_o, oup_dec_err_o, inp_ready_o} !== 8'b0001_00_1_0) begin failures++; $display("FAIL err_hold%0d: got %b want 00010010", c, {oup_valid_o, oup_sel_o, oup_dec_err_o, inp_ready_o}); end
            if (c == 2) set_rule(2, 16'h7000, 16'hF000, 2'd3, 1'b1);
            tick();
        end
        oup_ready = 4'b0001;
        tick();
        checks++; if ({oup_valid_o, outstanding_o} !== 8'h01) begin failures++; $display("FAIL err_drain: got %h want 01", {oup_valid_o, outstanding_o}); end
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        oup_ready = 4'hF;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [6:0] got, want;
        clear_rules();
        set_rule(0, 16'h1000, 16'hF000, 2'd1, 1'b1);
        oup_ready = 4'hF;
        addr = 16'h1000;
        inp_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_ready%0d: got %b want 1", b, inp_ready_o); end
            sb.push_back('{sel: 2'd1, err: 1'b0});
            tick();
            if (b == 3) begin
                inp_valid = 1'b0;
                oup_ready = 4'h0;
            end
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL rmid_sb%0d: output with empty scoreboard", b); end
            else begin
                e = sb.pop_front();
                got  = {oup_valid_o, oup_sel_o, oup_dec_err_o};
                want = {4'b0001 << e.sel, e.sel, e.err};
                if (got !== want) begin failures++; $display("FAIL rmid_out%0d: got %b want %b", b, got, want); end
            end
        end
        #1;
        checks++; if ({oup_valid_o, outstanding_o, busy_o} !== 9'b0010_0100_1) begin failures++; $display("FAIL rmid_pre: got %b want 001001001", {oup_valid_o, outstanding_o, busy_o}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({oup_valid_o, outstanding_o, busy_o, oup_dec_err_o, oup_sel_o} !== 12'h000) begin failures++; $display("FAIL rmid_post: got %b want 0", {oup_valid_o, outstanding_o, busy_o, oup_dec_err_o, oup_sel_o}); end
        checks++; if (inp_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", inp_ready_o); end
        oup_ready = 4'hF;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        inp_valid  = 1'b0;
        inp_valid2 = 1'b0;
        addr       = '0;
        oup_ready  = 4'hF;
        rsp_done   = 1'b0;
        rsp_done2  = 1'b0;
        clear_rules();

        test_reset();
        test_basic();
        test_priority();
        test_target_switch();
        test_max_trans();
        test_dec_err_hold();
        test_reset_mid();

        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_empty: got %0d entries want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
